// File: rtl/ula_pkg.sv
// Shared opcode encoding, instruction classes, FSM states and error codes
// for the ALU issue sequencer.
package ula_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_PUSH  = 5'b00010;
  localparam logic [4:0] OP_POP   = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00101;
  localparam logic [4:0] OP_MUL   = 5'b00110;
  localparam logic [4:0] OP_DIV   = 5'b00111;
  localparam logic [4:0] OP_MOD   = 5'b01000;
  localparam logic [4:0] OP_AND   = 5'b01001;
  localparam logic [4:0] OP_OR    = 5'b01010;
  localparam logic [4:0] OP_XOR   = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_NOT   = 5'b01101;
  localparam logic [4:0] OP_IF_EQ = 5'b01111;
  localparam logic [4:0] OP_IF_NE = 5'b10000;
  localparam logic [4:0] OP_IF_LT = 5'b10001;
  localparam logic [4:0] OP_IF_GT = 5'b10010;
  localparam logic [4:0] OP_IF_LE = 5'b10011;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_ILL   = 2'd3;

  typedef enum logic [2:0] {
    CL_PUSH,
    CL_POP,
    CL_BIN,
    CL_UN,
    CL_IF,
    CL_ILL
  } cls_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  function automatic cls_e ula_decode(input logic [4:0] op);
    cls_e c;
    c = CL_ILL;
    unique case (1'b1)
      op == OP_PUSH:                    c = CL_PUSH;
      op == OP_POP:                     c = CL_POP;
      op >= OP_ADD && op <= OP_CMP:     c = CL_BIN;
      op == OP_NOT:                     c = CL_UN;
      op >= OP_IF_EQ && op <= OP_IF_LE: c = CL_IF;
      default:                          c = CL_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] ula_pops(input cls_e c);
    logic [1:0] n;
    n = 2'd0;
    unique case (1'b1)
      c == CL_BIN:                n = 2'd2;
      c == CL_POP || c == CL_UN:  n = 2'd1;
      c == CL_IF:                 n = 2'd1;
      default:                    n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ula_stack.sv
// Operand LIFO: pops 0..2 entries and optionally pushes one per cycle,
// exposing top/second-from-top and the current depth.
module ula_stack #(
  parameter int DEPTH = 8,
  parameter int DEPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pop_n,
  input  logic            push,
  input  logic [15:0]     push_data,
  output logic [15:0]     top,
  output logic [15:0]     second,
  output logic [DEPW-1:0] depth
);

  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     mem_d [DEPTH];
  logic [DEPW-1:0] depth_q;
  logic [DEPW-1:0] depth_d;
  logic [DEPW-1:0] wr_idx;

  always_comb begin
    top    = '0;
    second = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DEPW'(i + 1) == depth_q) top = mem_q[i];
      if (DEPW'(i + 2) == depth_q) second = mem_q[i];
    end
  end

  // Push lands just above whatever survives the pops.
  always_comb begin
    mem_d   = mem_q;
    wr_idx  = depth_q - DEPW'(pop_n);
    depth_d = wr_idx + DEPW'(push);
    for (int i = 0; i < DEPTH; i++) begin
      if (push && DEPW'(i) == wr_idx) mem_d[i] = push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      depth_q <= '0;
    end else begin
      mem_q   <= mem_d;
      depth_q <= depth_d;
    end
  end

  assign depth = depth_q;

endmodule

// File: rtl/ula_sequencer.sv
// Stack-machine issue stage for the combinational ALU (IDLE/EXEC/WB).
// Define DIV_ZERO_TRAP_EN to trap Div with a zero divisor as err=3.
module ula_sequencer
  import ula_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DEPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [4:0]      instr_opcode,
  input  logic [15:0]     instr_imm,
  output logic [15:0]     alu_op1,
  output logic [15:0]     alu_op2,
  output logic [4:0]      alu_opcode,
  input  logic [31:0]     alu_result,
  input  logic            alu_cond,
  output logic            done,
  output logic            cond_taken,
  output logic [1:0]      err,
  output logic [15:0]     stack_top,
  output logic [DEPW-1:0] depth
);

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d, acc_cls;
  logic [4:0]  op_q, op_d;
  logic [15:0] imm_q, imm_d;
  logic [15:0] top_q, top_d;
  logic [15:0] sec_q, sec_d;
  logic [1:0]  err_q, err_d, acc_err;
  logic        cond_q, cond_d;

  logic [1:0]      pop_n;
  logic            push;
  logic [15:0]     stk_top;
  logic [15:0]     stk_sec;
  logic [DEPW-1:0] stk_depth;
  logic            unused_res;

  assign unused_res = ^alu_result[31:16];

  ula_stack #(
    .DEPTH(DEPTH),
    .DEPW (DEPW)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .pop_n    (pop_n),
    .push     (push),
    .push_data(alu_result[15:0]),
    .top      (stk_top),
    .second   (stk_sec),
    .depth    (stk_depth)
  );

  always_comb begin
    acc_cls = ula_decode(instr_opcode);
    acc_err = ERR_OK;
    if (acc_cls == CL_ILL)
      acc_err = ERR_ILL;
    else if (DEPW'(ula_pops(acc_cls)) > stk_depth)
      acc_err = ERR_UNDER;
    else if (acc_cls == CL_PUSH && stk_depth == DEPW'(DEPTH))
      acc_err = ERR_OVER;
`ifdef DIV_ZERO_TRAP_EN
    else if (instr_opcode == OP_DIV && stk_top == '0)
      acc_err = ERR_ILL;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    op_d        = op_q;
    imm_d       = imm_q;
    top_d       = top_q;
    sec_d       = sec_q;
    err_d       = err_q;
    cond_d      = cond_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    alu_op1     = '0;
    alu_op2     = '0;
    alu_opcode  = OP_NOP;
    pop_n       = 2'd0;
    push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          cls_d   = acc_cls;
          op_d    = instr_opcode;
          imm_d   = instr_imm;
          top_d   = stk_top;
          sec_d   = stk_sec;
          err_d   = acc_err;
          cond_d  = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        // Faulting instructions leave the ALU idle and the stack alone.
        if (err_q == ERR_OK) begin
          case (cls_q)
            CL_PUSH: begin
              alu_op1    = imm_q;
              alu_opcode = op_q;
              push       = 1'b1;
            end
            CL_POP: pop_n = 2'd1;
            CL_BIN: begin
              alu_op1    = sec_q;
              alu_op2    = top_q;
              alu_opcode = op_q;
              pop_n      = 2'd2;
              push       = 1'b1;
            end
            CL_UN: begin
              alu_op1    = top_q;
              alu_opcode = op_q;
              pop_n      = 2'd1;
              push       = 1'b1;
            end
            CL_IF: begin
              alu_op1    = top_q;
              alu_opcode = op_q;
              pop_n      = 2'd1;
              cond_d     = alu_cond;
            end
            default: ;
          endcase
        end
      end
      S_WB: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= CL_ILL;
      op_q    <= '0;
      imm_q   <= '0;
      top_q   <= '0;
      sec_q   <= '0;
      err_q   <= ERR_OK;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      top_q   <= top_d;
      sec_q   <= sec_d;
      err_q   <= err_d;
      cond_q  <= cond_d;
    end
  end

  assign err        = (state_q == S_WB) ? err_q : ERR_OK;
  assign cond_taken = (state_q == S_WB) && cond_q;
  assign stack_top  = stk_top;
  assign depth      = stk_depth;

endmodule
